// File: rtl/calc2_pkg.sv
// calc2_pkg: shared types, tag sizing and small helpers for the calc2 port issuer.
package calc2_pkg;
    localparam int TAG_W    = 2;
    localparam int NUM_TAGS = 2 ** TAG_W;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   cnt_t;
    typedef logic [NUM_TAGS-1:0] tag_vec_t;
    typedef enum logic [3:0] {NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, SHL = 4'd5, SHR = 4'd6} cmd_e;
    typedef enum logic [1:0] {NONE = 2'd0, OK = 2'd1, ERR = 2'd2, RSVD = 2'd3} resp_e;
    typedef enum logic [1:0] {IDLE, CMD, OPB} state_e;
    function automatic tag_t lowest_set(input tag_vec_t v);
        lowest_set = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (v[i]) lowest_set = tag_t'(i);
    endfunction
    function automatic tag_vec_t onehot(input tag_t t);
        onehot = tag_vec_t'(1) << t;
    endfunction
    function automatic cnt_t popcount(input tag_vec_t v);
        popcount = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            popcount = popcount + cnt_t'(v[i]);
    endfunction
endpackage

// File: rtl/calc2_port_issuer_if.sv
// calc2_port_issuer_if: operation, calc2 request/response and result bundle.
interface calc2_port_issuer_if #(parameter int DATA_W = 32);
    import calc2_pkg::*;
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_cmd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        req_cmd_in;
    logic [DATA_W-1:0] req_data_in;
    tag_t              req_tag_in;
    logic [1:0]        out_resp;
    logic [DATA_W-1:0] out_data;
    tag_t              out_tag;
    logic              res_valid;
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_data;
    tag_t              res_tag;
    logic              err_unexp;
    logic              timeout;
    tag_t              timeout_tag;
    logic [2:0]        inflight;
    modport master (
        output op_valid, op_cmd, op_a, op_b, out_resp, out_data, out_tag,
        input  op_ready, req_cmd_in, req_data_in, req_tag_in, res_valid, res_resp,
               res_data, res_tag, err_unexp, timeout, timeout_tag, inflight
    );
    modport slave (
        input  op_valid, op_cmd, op_a, op_b, out_resp, out_data, out_tag,
        output op_ready, req_cmd_in, req_data_in, req_tag_in, res_valid, res_resp,
               res_data, res_tag, err_unexp, timeout, timeout_tag, inflight
    );
endinterface

// File: rtl/calc2_tag_tracker.sv
// calc2_tag_tracker: busy vector, lowest-free allocation, per-tag watchdog ages and expiry arbitration.
module calc2_tag_tracker
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc,
    input  logic       retire,
    input  tag_t       retire_tag,
    output tag_t       free_tag,
    output logic       any_free,
    output logic       hit,
    output logic       timeout,
    output tag_t       timeout_tag,
    output logic [2:0] inflight
);
    localparam int AGE_W = $clog2(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT - 1);
    tag_vec_t busy, busy_n, ret_mask, cand;
    logic [AGE_W-1:0] age [NUM_TAGS];
    logic exp_any;
    tag_t exp_tag;
    always_comb begin
        hit      = busy[retire_tag];
        ret_mask = (retire && hit) ? onehot(retire_tag) : '0;
        cand     = '0;
        for (int t = 0; t < NUM_TAGS; t++)
            cand[t] = busy[t] && (age[t] == AGE_MAX) && !ret_mask[t];
        exp_any  = |cand;
        exp_tag  = lowest_set(cand);
        free_tag = lowest_set(~busy);
        any_free = ~&busy;
        // a response racing its own expiry wins; unchosen expiries stay busy at AGE_MAX
        busy_n   = (busy & ~ret_mask & ~(exp_any ? onehot(exp_tag) : '0)) | (alloc ? onehot(free_tag) : '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            timeout     <= 1'b0;
            timeout_tag <= '0;
            inflight    <= '0;
            for (int t = 0; t < NUM_TAGS; t++) age[t] <= '0;
        end else begin
            busy        <= busy_n;
            timeout     <= exp_any;
            timeout_tag <= exp_any ? exp_tag : '0;
            inflight    <= popcount(busy_n);
            for (int t = 0; t < NUM_TAGS; t++)
                age[t] <= (alloc && free_tag == tag_t'(t)) ? '0 :
                          (busy[t] && age[t] != AGE_MAX) ? age[t] + 1'b1 : age[t];
        end
    end
endmodule

// File: rtl/calc2_port_issuer.sv
// calc2_port_issuer: accepts whole operations, drives the two-cycle calc2 request and retires tagged results.
module calc2_port_issuer
    import calc2_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic c_clk,
    input logic reset,
    calc2_port_issuer_if.slave io
);
    state_e state, state_n;
    logic [DATA_W-1:0] b_q, data_n;
    logic [3:0] cmd_n;
    tag_t tag_n, free_tag;
    logic ready, accept, retire, hit, any_free;
    assign ready       = (state == IDLE) && any_free && !reset;
    assign io.op_ready = ready;
    assign accept      = io.op_valid && ready;
    assign retire      = io.out_resp != NONE;
    calc2_tag_tracker #(.TIMEOUT(TIMEOUT)) u_tracker (
        .clk        (c_clk),
        .rst        (reset),
        .alloc      (accept),
        .retire     (retire),
        .retire_tag (io.out_tag),
        .free_tag   (free_tag),
        .any_free   (any_free),
        .hit        (hit),
        .timeout    (io.timeout),
        .timeout_tag(io.timeout_tag),
        .inflight   (io.inflight)
    );
    always_comb begin
        state_n = (state == IDLE) ? (accept ? CMD : IDLE) : (state == CMD) ? OPB : IDLE;
        cmd_n   = accept ? io.op_cmd : '0;
        data_n  = accept ? io.op_a : (state == CMD) ? b_q : '0;
        tag_n   = accept ? free_tag : (state == CMD) ? io.req_tag_in : '0;
    end
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state          <= IDLE;
            b_q            <= '0;
            io.req_cmd_in  <= '0;
            io.req_data_in <= '0;
            io.req_tag_in  <= '0;
            io.res_valid   <= 1'b0;
            io.res_resp    <= '0;
            io.res_data    <= '0;
            io.res_tag     <= '0;
            io.err_unexp   <= 1'b0;
        end else begin
            state          <= state_n;
            b_q            <= accept ? io.op_b : b_q;
            io.req_cmd_in  <= cmd_n;
            io.req_data_in <= data_n;
            io.req_tag_in  <= tag_n;
            io.res_valid   <= retire && hit;
            io.res_resp    <= (retire && hit) ? io.out_resp : '0;
            io.res_data    <= (retire && hit) ? io.out_data : '0;
            io.res_tag     <= (retire && hit) ? io.out_tag : '0;
            io.err_unexp   <= retire && !hit;
        end
    end
endmodule

// File: tb/tb_calc2_port_issuer.sv
// tb_calc2_port_issuer: directed stimulus with a result scoreboard drained by an independent monitor.
module tb_calc2_port_issuer;
    import calc2_pkg::*;
    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        tag_t        tag;
    } res_t;
    logic c_clk = 1'b0;
    logic reset = 1'b1;
    int n_pass = 0, n_chk = 0, cyc = 0, err_seen = 0, to_seen = 0, cmd_cyc = 0;
    res_t exp_q[$];
    always #5 c_clk = ~c_clk;
    calc2_port_issuer_if io();
    calc2_port_issuer dut (.c_clk(c_clk), .reset(reset), .io(io));
    always @(posedge c_clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    // Monitor: every retired result must match the oldest expectation
    always @(negedge c_clk) begin
        res_t e;
        if (!reset) begin
            if (io.res_valid) begin
                if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("res_resp", io.res_resp, e.resp);
                    chk("res_data", io.res_data, e.data);
                    chk("res_tag", io.res_tag, e.tag);
                end
            end
            if (io.err_unexp) err_seen++;
            if (io.timeout) to_seen++;
        end
    end
    task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input tag_t t);
        int n = 0;
        while (!io.op_ready && n < 200) begin
            @(negedge c_clk);
            n++;
        end
        chk("ready_wait", io.op_ready, 1);
        io.op_valid = 1'b1;
        io.op_cmd   = cmd;
        io.op_a     = a;
        io.op_b     = b;
        @(negedge c_clk);
        io.op_valid = 1'b0;
        cmd_cyc     = cyc;
        chk("cmd_cmd", io.req_cmd_in, cmd);
        chk("cmd_data", io.req_data_in, a);
        chk("cmd_tag", io.req_tag_in, t);
        chk("cmd_ready", io.op_ready, 0);
        @(negedge c_clk);
        chk("opb_cmd", io.req_cmd_in, 0);
        chk("opb_data", io.req_data_in, b);
        chk("opb_tag", io.req_tag_in, t);
    endtask
    task automatic respond(input logic [1:0] resp, input logic [31:0] data, input tag_t t, input logic want);
        if (want) exp_q.push_back('{resp: resp, data: data, tag: t});
        io.out_resp = resp;
        io.out_data = data;
        io.out_tag  = t;
        @(negedge c_clk);
        io.out_resp = '0;
        io.out_data = '0;
        io.out_tag  = '0;
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
    initial begin
        int n;
        io.op_valid = 1'b0;
        io.op_cmd   = '0;
        io.op_a     = '0;
        io.op_b     = '0;
        io.out_resp = '0;
        io.out_data = '0;
        io.out_tag  = '0;
        repeat (3) @(negedge c_clk);
        chk("rst_ready", io.op_ready, 0);
        chk("rst_req_cmd", io.req_cmd_in, 0);
        chk("rst_inflight", io.inflight, 0);
        chk("rst_res_valid", io.res_valid, 0);
        chk("rst_timeout", io.timeout, 0);
        reset = 1'b0;
        @(negedge c_clk);
        chk("ready_after_rst", io.op_ready, 1);
        // ADD 5+7
        do_op(ADD, 5, 7, 0);
        chk("add_inflight", io.inflight, 1);
        respond(OK, 32'hC, 0, 1);
        chk("add_inflight_done", io.inflight, 0);
        // fill all four tags
        for (int i = 0; i < 4; i++) do_op(ADD, 32'(i), 32'(i), tag_t'(i));
        @(negedge c_clk);
        chk("full_inflight", io.inflight, 4);
        chk("full_ready", io.op_ready, 0);
        respond(OK, 32'h30, 2, 1);
        chk("freed_inflight", io.inflight, 3);
        do_op(SHL, 1, 3, 2);
        chk("refill_inflight", io.inflight, 4);
        // out-of-order retirement
        respond(OK, 32'h33, 3, 1);
        respond(OK, 32'h00, 0, 1);
        respond(OK, 32'h11, 1, 1);
        respond(OK, 32'h08, 2, 1);
        chk("ooo_inflight", io.inflight, 0);
        chk("ooo_err", err_seen, 0);
        // underflow and an unfiltered invalid command
        do_op(SUB, 0, 1, 0);
        respond(ERR, 32'hFFFF_FFFF, 0, 1);
        do_op(4'd4, 9, 3, 0);
        respond(ERR, 32'h0, 0, 1);
        // watchdog expiry then a late response
        do_op(ADD, 1, 1, 0);
        n = 0;
        while (!io.timeout && n < 100) begin
            @(negedge c_clk);
            n++;
        end
        chk("timeout_seen", io.timeout, 1);
        chk("timeout_dist", 64'(cyc - cmd_cyc), 64);
        chk("timeout_tag", io.timeout_tag, 0);
        chk("timeout_inflight", io.inflight, 0);
        respond(OK, 32'h2, 0, 0);
        chk("late_err", io.err_unexp, 1);
        chk("late_no_res", io.res_valid, 0);
        // reset during the OPB cycle
        chk("pre_rst_ready", io.op_ready, 1);
        io.op_valid = 1'b1;
        io.op_cmd   = ADD;
        io.op_a     = 8;
        io.op_b     = 9;
        @(negedge c_clk);
        io.op_valid = 1'b0;
        @(negedge c_clk);
        chk("opb_before_rst", io.req_data_in, 9);
        reset = 1'b1;
        @(negedge c_clk);
        chk("abort_cmd", io.req_cmd_in, 0);
        chk("abort_data", io.req_data_in, 0);
        chk("abort_tag", io.req_tag_in, 0);
        chk("abort_inflight", io.inflight, 0);
        chk("abort_ready", io.op_ready, 0);
        reset = 1'b0;
        @(negedge c_clk);
        chk("post_rst_ready", io.op_ready, 1);
        chk("post_rst_inflight", io.inflight, 0);
        chk("to_count", to_seen, 1);
        chk("err_count", err_seen, 1);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
